// File: rtl/syndrome_scheduler_pkg.sv
// Shared types and slot-plan tables for the syndrome scheduler.
// The plan is a pure function of the mode and code latched at frame start.
package syndrome_sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SYN = 2'd1,
      ISSUE    = 2'd2,
      DRAIN    = 2'd3
   } sched_state_e;

   localparam logic [1:0] CODE_SHORT0  = 2'b00;
   localparam logic [1:0] CODE_SHORT1  = 2'b01;
   localparam logic [1:0] CODE_LONG    = 2'b10;
   localparam logic [1:0] CODE_ILLEGAL = 2'b11;

   localparam logic [2:0] SLOTS_HARD       = 3'd1;
   localparam logic [2:0] SLOTS_SOFT_SHORT = 3'd2;
   localparam logic [2:0] SLOTS_SOFT_LONG  = 3'd4;

   localparam logic [3:0] MASK_HARD     = 4'b0001;
   localparam logic [3:0] MASK_SHORT_LO = 4'b0011;
   localparam logic [3:0] MASK_SHORT_HI = 4'b1100;

   function automatic logic [2:0] slot_count(input logic mode, input logic [1:0] code);
      if (!mode)
         return SLOTS_HARD;
      if (code == CODE_LONG)
         return SLOTS_SOFT_LONG;
      return SLOTS_SOFT_SHORT;
   endfunction

   // Long soft frames carry one test pattern per slot, short ones pair them up.
   function automatic logic [3:0] slot_mask(input logic mode, input logic [1:0] code,
                                            input logic [1:0] idx);
      if (!mode)
         return MASK_HARD;
      if (code == CODE_LONG)
         return 4'b0001 << idx;
      return idx[0] ? MASK_SHORT_HI : MASK_SHORT_LO;
   endfunction

endpackage

// File: rtl/syndrome_scheduler_if.sv
// Frame control, switch advance and solver slot handshake of the scheduler.
// slave = scheduler side, master = switch/solver/control side.
interface syndrome_scheduler_if;
   logic       i_start;
   logic       i_mode;
   logic [1:0] i_code;
   logic       i_tp1_valid;
   logic       i_all_tp_valid;
   logic       i_dec_ready;
   logic       i_dec_done;
   logic       o_next_tp;
   logic       o_slot_valid;
   logic [1:0] o_slot_idx;
   logic [3:0] o_tp_mask;
   logic       o_last_slot;
   logic       o_busy;
   logic       o_frame_done;
   logic       o_err;

   modport slave (
      input  i_start, i_mode, i_code, i_tp1_valid, i_all_tp_valid, i_dec_ready, i_dec_done,
      output o_next_tp, o_slot_valid, o_slot_idx, o_tp_mask, o_last_slot, o_busy,
             o_frame_done, o_err
   );

   modport master (
      output i_start, i_mode, i_code, i_tp1_valid, i_all_tp_valid, i_dec_ready, i_dec_done,
      input  o_next_tp, o_slot_valid, o_slot_idx, o_tp_mask, o_last_slot, o_busy,
             o_frame_done, o_err
   );
endinterface

// File: rtl/syndrome_scheduler_credit_counter.sv
// Solver credit pool: one credit per outstanding slot, returned by i_inc.
// o_credits_avail looks at the post-update count so a registered valid can use it.
module sched_credit_counter #(
   parameter int CREDITS = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_credits_avail,
   output logic o_credits_full,
   output logic o_overflow
);

   localparam logic [1:0] CRED_MAX = 2'(CREDITS);

   logic [1:0] credits_q, credits_d;
   logic       ovf;

   always_comb begin
      ovf       = i_inc && (credits_q == CRED_MAX);
      credits_d = credits_q;
      // A return with a full pool is a solver bookkeeping error and is dropped.
      if (i_inc && !ovf)
         credits_d = credits_d + 2'd1;
      if (i_dec)
         credits_d = credits_d - 2'd1;
   end

   assign o_credits_avail = (credits_d != 2'd0);
   assign o_credits_full  = (credits_q == CRED_MAX);
   assign o_overflow      = ovf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         credits_q <= CRED_MAX;
      else
         credits_q <= credits_d;
   end

endmodule

// File: rtl/syndrome_scheduler.sv
// Sequences a frame's syndrome slots into the key-equation solver under credit control.
// First slot valid 1 cycle after syndromes are ready; holds slot until i_dec_ready, stalls on zero credits.
module syndrome_scheduler
   import syndrome_sched_pkg::*;
#(
   parameter int CREDITS     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                i_clk,
   input  logic                i_rst,
   syndrome_scheduler_if.slave bus
);

   sched_state_e state_q, state_d;
   logic         mode_q, mode_d;
   logic [1:0]   code_q, code_d;
   logic [2:0]   slot_cnt_q, slot_cnt_d;
   logic [7:0]   tmo_q, tmo_d;
   logic         slot_valid_q, slot_valid_d;
   logic [1:0]   slot_idx_q, slot_idx_d;
   logic [3:0]   tp_mask_q, tp_mask_d;
   logic         last_slot_q, last_slot_d;
   logic         busy_q, busy_d;
   logic         frame_done_q, frame_done_d;
   logic         err_q, err_d;

   logic issue;
   logic abort;
   logic timed_out;
   logic credits_avail;
   logic credits_full;
   logic credit_ovf;

   assign issue     = slot_valid_q & bus.i_dec_ready;
   assign timed_out = (tmo_q == 8'(TIMEOUT_CYC));

   sched_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credits (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_inc           (bus.i_dec_done),
      .i_dec           (issue),
      .o_credits_avail (credits_avail),
      .o_credits_full  (credits_full),
      .o_overflow      (credit_ovf)
   );

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      code_d       = code_q;
      slot_cnt_d   = slot_cnt_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      abort        = 1'b0;

      if (bus.i_start) begin
         if (state_q != IDLE || !credits_full)
            err_d = 1'b1;
         else if (bus.i_mode && bus.i_code == CODE_ILLEGAL)
            err_d = 1'b1;
         else begin
            mode_d     = bus.i_mode;
            code_d     = bus.i_code;
            slot_cnt_d = 3'd0;
            state_d    = WAIT_SYN;
         end
      end

      case (state_q)
         WAIT_SYN: begin
            if (!bus.i_tp1_valid)
               abort = 1'b1;
            else if (!mode_q || bus.i_all_tp_valid)
               state_d = ISSUE;
         end
         ISSUE: begin
            if (!bus.i_tp1_valid || timed_out)
               abort = 1'b1;
            else if (issue) begin
               slot_cnt_d = slot_cnt_q + 3'd1;
               if (last_slot_q)
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!bus.i_tp1_valid || timed_out)
               abort = 1'b1;
            else if (credits_full) begin
               frame_done_d = 1'b1;
               slot_cnt_d   = 3'd0;
               state_d      = IDLE;
            end
         end
         default: ;
      endcase

      // Slots already handed to the solver keep their credit; it comes back via i_dec_done.
      if (abort) begin
         err_d      = 1'b1;
         state_d    = IDLE;
         slot_cnt_d = 3'd0;
      end
      if (credit_ovf)
         err_d = 1'b1;

      if (state_d != state_q || issue || bus.i_dec_done)
         tmo_d = 8'd0;
      else if (state_q == ISSUE || state_q == DRAIN)
         tmo_d = tmo_q + 8'd1;
      else
         tmo_d = 8'd0;

      slot_valid_d = (state_d == ISSUE) && credits_avail;
      slot_idx_d   = 2'd0;
      tp_mask_d    = 4'd0;
      last_slot_d  = 1'b0;
      if (state_d == ISSUE) begin
         slot_idx_d  = slot_cnt_d[1:0];
         tp_mask_d   = slot_mask(mode_q, code_q, slot_cnt_d[1:0]);
         last_slot_d = (slot_cnt_d + 3'd1 == slot_count(mode_q, code_q));
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         mode_q       <= 1'b0;
         code_q       <= 2'd0;
         slot_cnt_q   <= 3'd0;
         tmo_q        <= 8'd0;
         slot_valid_q <= 1'b0;
         slot_idx_q   <= 2'd0;
         tp_mask_q    <= 4'd0;
         last_slot_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         code_q       <= code_d;
         slot_cnt_q   <= slot_cnt_d;
         tmo_q        <= tmo_d;
         slot_valid_q <= slot_valid_d;
         slot_idx_q   <= slot_idx_d;
         tp_mask_q    <= tp_mask_d;
         last_slot_q  <= last_slot_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   // The switch advance rides on the handshake itself, so it is not registered.
   assign bus.o_next_tp    = issue & ~last_slot_q;
   assign bus.o_slot_valid = slot_valid_q;
   assign bus.o_slot_idx   = slot_idx_q;
   assign bus.o_tp_mask    = tp_mask_q;
   assign bus.o_last_slot  = last_slot_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_frame_done = frame_done_q;
   assign bus.o_err        = err_q;

endmodule

// File: tb/tb_syndrome_scheduler.sv
// Bench for syndrome_scheduler: directed corner cases plus randomized frames
// checked against a slot-queue / credit-count reference model.
module tb_syndrome_scheduler;

   localparam int CRED = 2;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   syndrome_scheduler_if bus();

   syndrome_scheduler #(
      .CREDITS     (CRED),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_start        = 1'b0;
      bus.i_mode         = 1'b0;
      bus.i_code         = 2'd0;
      bus.i_tp1_valid    = 1'b1;
      bus.i_all_tp_valid = 1'b0;
      bus.i_dec_ready    = 1'b0;
      bus.i_dec_done     = 1'b0;
   endtask

   // One frame: the model keeps the expected masks as a queue, the credit pool as an
   // integer, and the solver's pending returns as a queue of return cycles.
   task automatic run_frame(input int mode, input int code, input int tp_lag,
                            input int dmin, input int dmax, input int rdy_pct, input int inject);
      int  q_mask[$];
      int  ret[$];
      int  cred      = CRED;
      int  issued    = 0;
      int  last_ret  = -100;
      int  last_sch  = -1;
      int  lowrun    = 0;
      int  exp_first;
      bit  done      = 1'b0;
      if (mode == 0)      q_mask = '{1};
      else if (code == 2) q_mask = '{1, 2, 4, 8};
      else                q_mask = '{3, 12};
      exp_first = (mode != 0 && tp_lag + 1 > 2) ? tp_lag + 1 : 2;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         int exp_valid, exp_fd, rdy, dd, t;
         bus.i_start        = (cyc == 0 || cyc == inject);
         bus.i_mode         = (cyc == 0) ? 1'(mode) : 1'($urandom_range(0, 1));
         bus.i_code         = (cyc == 0) ? 2'(code) : 2'($urandom_range(0, 3));
         bus.i_tp1_valid    = 1'b1;
         bus.i_all_tp_valid = (cyc >= tp_lag);
         dd = (ret.size() > 0 && ret[0] == cyc) ? 1 : 0;
         bus.i_dec_done     = 1'(dd);
         rdy = (lowrun >= 3) ? 1 : ((int'($urandom_range(0, 99)) < rdy_pct) ? 1 : 0);
         lowrun = rdy ? 0 : lowrun + 1;
         bus.i_dec_ready    = 1'(rdy);
         @(negedge clk);
         exp_valid = (cyc >= exp_first && q_mask.size() > 0 && cred > 0) ? 1 : 0;
         exp_fd    = (q_mask.size() == 0 && ret.size() == 0 && cyc == last_ret + 2) ? 1 : 0;
         check_eq("slot_valid", int'(bus.o_slot_valid), exp_valid);
         if (exp_valid == 1 && bus.o_slot_valid) begin
            check_eq("slot_idx", int'(bus.o_slot_idx), issued);
            check_eq("tp_mask", int'(bus.o_tp_mask), q_mask[0]);
            check_eq("last_slot", int'(bus.o_last_slot), (q_mask.size() == 1) ? 1 : 0);
         end
         check_eq("next_tp", int'(bus.o_next_tp), (exp_valid == 1 && rdy == 1 && q_mask.size() > 1) ? 1 : 0);
         check_eq("err", int'(bus.o_err), (cyc == inject + 1) ? 1 : 0);
         check_eq("frame_done", int'(bus.o_frame_done), exp_fd);
         if (cyc == 1)
            check_eq("busy_start", int'(bus.o_busy), 1);
         if (exp_fd == 1) begin
            check_eq("busy_done", int'(bus.o_busy), 0);
            done = 1'b1;
         end
         if (dd == 1) begin
            void'(ret.pop_front());
            cred++;
            last_ret = cyc;
         end
         if (exp_valid == 1 && rdy == 1) begin
            t = cyc + int'($urandom_range(dmin, dmax));
            if (t <= last_sch) t = last_sch + 1;
            ret.push_back(t);
            last_sch = t;
            void'(q_mask.pop_front());
            issued++;
            cred--;
         end
         tick();
      end
      if (!done)
         check_eq("frame_timeout", 0, 1);
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_slot_valid", int'(bus.o_slot_valid), 0);
      check_eq("rst_next_tp", int'(bus.o_next_tp), 0);
      check_eq("rst_busy", int'(bus.o_busy), 0);
      check_eq("rst_frame_done", int'(bus.o_frame_done), 0);
      check_eq("rst_err", int'(bus.o_err), 0);
      check_eq("rst_tp_mask", int'(bus.o_tp_mask), 0);
      check_eq("rst_last_slot", int'(bus.o_last_slot), 0);
      tick();

      run_frame(0, 1, 0, 1, 1, 100, -10);
      run_frame(1, 0, 0, 1, 1, 100, -10);
      run_frame(1, 2, 0, 5, 5, 100, -10);
      run_frame(1, 2, 0, 1, 1, 100, -10);
      run_frame(1, 0, 3, 2, 4, 100, -10);
      run_frame(1, 2, 0, 2, 4, 100, 3);

      // Illegal soft code: error only, never leaves IDLE.
      bus.i_start = 1'b1; bus.i_mode = 1'b1; bus.i_code = 2'b11;
      @(negedge clk);
      check_eq("illegal_err_early", int'(bus.o_err), 0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_eq("illegal_err", int'(bus.o_err), 1);
      check_eq("illegal_busy", int'(bus.o_busy), 0);
      tick();
      @(negedge clk);
      check_eq("illegal_err_clear", int'(bus.o_err), 0);
      tick();

      // Credit returned with a full pool.
      bus.i_dec_done = 1'b1;
      tick();
      bus.i_dec_done = 1'b0;
      @(negedge clk);
      check_eq("spurious_done_err", int'(bus.o_err), 1);
      tick();
      run_frame(1, 0, 0, 1, 3, 100, -10);

      // tp1_valid drops while a slot is being offered.
      bus.i_start = 1'b1; bus.i_mode = 1'b1; bus.i_code = 2'b00; bus.i_all_tp_valid = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick();
      @(negedge clk);
      check_eq("drop_valid", int'(bus.o_slot_valid), 1);
      tick();
      bus.i_tp1_valid = 1'b0;
      @(negedge clk);
      check_eq("drop_err_early", int'(bus.o_err), 0);
      tick();
      bus.i_tp1_valid = 1'b1;
      @(negedge clk);
      check_eq("drop_err", int'(bus.o_err), 1);
      check_eq("drop_busy", int'(bus.o_busy), 0);
      check_eq("drop_valid_off", int'(bus.o_slot_valid), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check_eq("drop_no_done", int'(bus.o_frame_done), 0);
      end
      tick();
      idle_inputs();

      // Solver never ready: watchdog abort.
      bus.i_start = 1'b1; bus.i_mode = 1'b0; bus.i_code = 2'b00;
      tick();
      bus.i_start = 1'b0;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         if (cyc == 10) begin
            check_eq("tmo_err_early", int'(bus.o_err), 0);
            check_eq("tmo_busy_early", int'(bus.o_busy), 1);
         end
         if (cyc == 11) begin
            check_eq("tmo_err", int'(bus.o_err), 1);
            check_eq("tmo_busy", int'(bus.o_busy), 0);
            check_eq("tmo_valid", int'(bus.o_slot_valid), 0);
         end
         tick();
      end
      idle_inputs();
      tick();

      for (int n = 0; n < 40; n++) begin
         int m, c;
         m = int'($urandom_range(0, 1));
         c = m ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
         run_frame(m, c, int'($urandom_range(0, 4)), 1, int'($urandom_range(1, 5)),
                   int'($urandom_range(50, 100)), ($urandom_range(0, 3) == 0) ? 3 : -10);
      end

      // Asynchronous reset in the middle of a frame.
      bus.i_start = 1'b1; bus.i_mode = 1'b1; bus.i_code = 2'b10; bus.i_all_tp_valid = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick();
      @(negedge clk);
      check_eq("arst_pre_valid", int'(bus.o_slot_valid), 1);
      rst = 1'b1;
      #1;
      check_eq("arst_valid", int'(bus.o_slot_valid), 0);
      check_eq("arst_busy", int'(bus.o_busy), 0);
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
      run_frame(1, 2, 0, 1, 2, 100, -10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
